// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, 32 iterations, with an
// optional single-cycle bypass for divide-by-zero and signed divide overflow.
module muldiv_unit #(
   parameter bit DIV_BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic        rd_we
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   // hi: running upper product / partial remainder; lo: multiplier / dividend-quotient
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   // opb: multiplicand magnitude or divisor magnitude
   logic [31:0] opb_q, opb_d;
   logic        sgn_q, sgn_d;      // product / quotient must be negated
   logic        aneg_q, aneg_d;    // dividend was negative (remainder sign)
   logic        spec_q, spec_d;    // divide special case, result overridden at the end
   logic [31:0] spec_res_q, spec_res_d;
   logic [31:0] result_q, result_d;

   // Operand decode at acceptance time
   logic        in_div, a_signed, b_signed, a_neg, b_neg, div_special;
   logic [31:0] a_mag, b_mag, spec_res;

   always_comb begin
      in_div      = funct3[2];
      a_signed    = in_div ? ~funct3[0] : (funct3 == 3'd1 || funct3 == 3'd2);
      b_signed    = in_div ? ~funct3[0] : (funct3 == 3'd1);
      a_neg       = a_signed & rs1_data[31];
      b_neg       = b_signed & rs2_data[31];
      a_mag       = a_neg ? (32'd0 - rs1_data) : rs1_data;
      b_mag       = b_neg ? (32'd0 - rs2_data) : rs2_data;
      div_special = 1'b0;
      spec_res    = 32'd0;
      if (in_div) begin
         if (rs2_data == 32'd0) begin
            div_special = 1'b1;
            spec_res    = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
         end else if (!funct3[0] && rs1_data == 32'h8000_0000 && rs2_data == 32'hFFFF_FFFF) begin
            div_special = 1'b1;
            spec_res    = funct3[1] ? 32'd0 : 32'h8000_0000;
         end
      end
   end

   // One iteration of shift-add multiply or restoring divide
   logic [32:0] mul_sum, div_trial, div_diff;
   logic        div_ge;
   logic [31:0] step_hi, step_lo;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
      div_trial = {hi_q, lo_q[31]};
      div_diff  = div_trial - {1'b0, opb_q};
      div_ge    = ~div_diff[32];
      if (op_q[2]) begin
         step_hi = div_ge ? div_diff[31:0] : div_trial[31:0];
         step_lo = {lo_q[30:0], div_ge};
      end else begin
         step_hi = mul_sum[32:1];
         step_lo = {mul_sum[0], lo_q[31:1]};
      end
   end

   // Sign fix-up and result selection after the last iteration
   logic [63:0] prod, prod_s;
   logic [31:0] quo_s, rem_s, final_res;

   always_comb begin
      prod   = {step_hi, step_lo};
      prod_s = sgn_q ? (64'd0 - prod) : prod;
      quo_s  = sgn_q ? (32'd0 - step_lo) : step_lo;
      rem_s  = aneg_q ? (32'd0 - step_hi) : step_hi;
      if (op_q[2]) begin
         if (spec_q)       final_res = spec_res_q;
         else if (op_q[1]) final_res = rem_s;
         else              final_res = quo_s;
      end else begin
         final_res = (op_q[1:0] == 2'd0) ? prod_s[31:0] : prod_s[63:32];
      end
   end

   // Next-state logic: accept in idle, iterate, pulse done
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      rd_d       = rd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      opb_d      = opb_q;
      sgn_d      = sgn_q;
      aneg_d     = aneg_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d       = funct3;
               rd_d       = rd_in;
               sgn_d      = a_neg ^ b_neg;
               aneg_d     = a_neg;
               spec_d     = div_special;
               spec_res_d = spec_res;
               hi_d       = 32'd0;
               cnt_d      = 5'd0;
               lo_d       = in_div ? a_mag : b_mag;
               opb_d      = in_div ? b_mag : a_mag;
               if (DIV_BYPASS && div_special) begin
                  state_d  = StDone;
                  result_d = spec_res;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = StDone;
               result_d = final_res;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         op_q       <= 3'd0;
         rd_q       <= 5'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         opb_q      <= 32'd0;
         sgn_q      <= 1'b0;
         aneg_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= 32'd0;
         result_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         opb_q      <= opb_d;
         sgn_q      <= sgn_d;
         aneg_q     <= aneg_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
      end
   end

   // Outputs derived from registered state
   always_comb begin
      busy   = (state_q != StIdle);
      done   = (state_q == StDone);
      result = result_q;
      rd_out = rd_q;
      rd_we  = done && (rd_q != 5'd0);
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus a per-cycle
// scoreboard of expected done/busy/result timing.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        rd_we;

   muldiv_unit #(.DIV_BYPASS(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out),
      .rd_we    (rd_we)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          acc;
      int          due;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_result = 32'd0;
   bit          chk_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, req);
      end
   endtask

   // Reference arithmetic straight from the RV32M definitions
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb64;
      logic [63:0] p;
      int          si, sj;
      if (!f3[2]) begin
         sa   = (f3 == 3'd1 || f3 == 3'd2) ? longint'($signed(a)) : longint'({32'd0, a});
         sb64 = (f3 == 3'd1) ? longint'($signed(b)) : longint'({32'd0, b});
         p    = sa * sb64;
         return (f3 == 3'd0) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
      if (!f3[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
         si = $signed(a);
         sj = $signed(b);
         return f3[1] ? 32'(si % sj) : 32'(si / sj);
      end
      return f3[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return f3[2] && (b == 32'd0 ||
                       (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Compare every cycle against the scoreboard
   always @(negedge clk) begin
      bit ed;
      bit eb;
      if (chk_en) begin
         ed = (sb.size() > 0) && (sb[0].due == cyc);
         eb = (sb.size() > 0) && (cyc > sb[0].acc) && (cyc <= sb[0].due);
         check32("done", {31'd0, done}, {31'd0, ed});
         check32("busy", {31'd0, busy}, {31'd0, eb});
         if (ed) begin
            exp_result = sb[0].res;
            check32("rd_out", {27'd0, rd_out}, {27'd0, sb[0].rd});
            check32("rd_we", {31'd0, rd_we}, {31'd0, sb[0].rd != 5'd0});
            void'(sb.pop_front());
         end else begin
            check32("rd_we_idle", {31'd0, rd_we}, 32'd0);
         end
         check32("result", result, exp_result);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op; poke>0 pulses a stray start that many cycles in, abort>0 resets
   task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit,
                        input int poke, input int abort);
      exp_t e;
      check32({name, "_model"}, model(f3, a, b), lit);
      funct3   = f3;
      rs1_data = a;
      rs2_data = b;
      rd_in    = rd;
      start    = 1'b1;
      e.acc    = cyc;
      e.due    = cyc + (is_special(f3, a, b) ? 1 : 33);
      e.res    = model(f3, a, b);
      e.rd     = rd;
      sb.push_back(e);
      step();
      start    = 1'b0;
      rs1_data = $urandom;
      rs2_data = $urandom;
      funct3   = 3'($urandom);
      rd_in    = 5'($urandom);
      while (cyc <= e.due) begin
         if (poke > 0 && cyc == e.acc + poke) begin
            start    = 1'b1;
            funct3   = 3'd0;
            rs1_data = 32'd1000;
            rs2_data = 32'd1000;
            rd_in    = 5'd9;
         end else begin
            start = 1'b0;
         end
         if (abort > 0 && cyc == e.acc + abort) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            sb.delete();
            exp_result = 32'd0;
            return;
         end
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      funct3   = 3'd0;
      rs1_data = 32'd0;
      rs2_data = 32'd0;
      rd_in    = 5'd0;
      repeat (3) step();
      check32("rst_busy", {31'd0, busy}, 32'd0);
      check32("rst_done", {31'd0, done}, 32'd0);
      check32("rst_result", result, 32'd0);
      check32("rst_rd_out", {27'd0, rd_out}, 32'd0);
      check32("rst_rd_we", {31'd0, rd_we}, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      step();

      issue("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 0, 0);
      issue("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0, 0);
      issue("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0, 0);
      issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 0, 0);
      issue("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFF1, 0, 0);
      issue("mulh_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFFF, 0, 0);
      issue("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 0, 0);
      issue("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 0, 0);
      issue("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 0, 0);
      issue("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 0, 0);
      issue("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 0, 0);
      issue("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 0, 0);
      issue("div_by0", 3'd4, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 0, 0);
      issue("remu_by0", 3'd7, 32'd5, 32'd0, 5'd13, 32'd5, 0, 0);
      issue("divu_by0", 3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0, 0);
      issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0, 0);
      issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 0, 0);
      issue("mul_poke", 3'd0, 32'd123, 32'd456, 5'd16, 32'd56088, 10, 0);
      issue("mul_rd0", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd1, 0, 0);
      issue("div_abort", 3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, 0, 15);
      step();
      issue("mul_3x3", 3'd0, 32'd3, 32'd3, 5'd18, 32'd9, 0, 0);

      // start coincident with reset while idle must be dropped
      rst      = 1'b1;
      start    = 1'b1;
      funct3   = 3'd0;
      rs1_data = 32'd11;
      rs2_data = 32'd11;
      rd_in    = 5'd19;
      step();
      rst   = 1'b0;
      start = 1'b0;
      exp_result = 32'd0;
      repeat (3) step();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
